// File: rtl/keypad_matrix_scan.sv
// Row-scanned R x C keypad with per-key debounce, a press/release event FIFO
// and a lowest-pressed-key code output.
module keypad_matrix_scan #(
  parameter int ROWS       = 4,
  parameter int COLS       = 3,
  parameter int SCAN_DIV   = 1024,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int CODE_W     = $clog2(ROWS*COLS+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   scan_en,
  input  logic [COLS-1:0]        keypad_col_n,
  output logic [ROWS-1:0]        keypad_row_n,
  output logic                   evt_valid,
  output logic [CODE_W:0]        evt_data,
  input  logic                   evt_ready,
  output logic [CODE_W-1:0]      key,
  output logic [ROWS*COLS-1:0]   keys_down,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam int NKEYS = ROWS * COLS;
  localparam int P_W   = $clog2(SCAN_DIV);
  localparam int R_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int K_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int I_W   = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int A_W   = $clog2(FIFO_DEPTH);
  localparam int EVT_W = CODE_W + 1;

  logic [COLS-1:0]   col_meta_q, col_sync_q;
  logic [P_W-1:0]    p_q, p_d;
  logic [R_W-1:0]    r_q, r_d;
  logic [ROWS-1:0]   row_n_q, row_n_d;
  logic [COLS-1:0]   samp_q, samp_d;
  logic [3:0]        cnt_q [NKEYS];
  logic [3:0]        cnt_d [NKEYS];
  logic [3:0]        cnt_inc;
  logic [NKEYS-1:0]  keys_q, keys_d;
  logic              proc_en;
  logic [K_W-1:0]    col_k;
  logic [I_W-1:0]    key_idx;
  logic [CODE_W-1:0] evt_code;
  logic              push;
  logic [EVT_W-1:0]  push_data;

  logic [EVT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [A_W-1:0]    wr_q, rd_q;
  logic [A_W:0]      fcnt_q, fcnt_d;
  logic              full, pop, accept, drop;
  logic              ovf_q, ovf_d;
  logic [CODE_W-1:0] key_enc;

  // Columns are asynchronous to clk; two flops before any use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
    end else begin
      col_meta_q <= keypad_col_n;
      col_sync_q <= col_meta_q;
    end
  end

  always_comb begin
    p_d = p_q;
    r_d = r_q;
    if (!scan_en) begin
      p_d = '0;
      r_d = '0;
    end else if (p_q == P_W'(SCAN_DIV-1)) begin
      p_d = '0;
      r_d = (r_q == R_W'(ROWS-1)) ? '0 : r_q + 1'b1;
    end else begin
      p_d = p_q + 1'b1;
    end
    for (int i = 0; i < ROWS; i++) begin
      row_n_d[i] = !(scan_en && (r_d == R_W'(i)));
    end
  end

  assign samp_d   = (scan_en && (p_q == P_W'(SCAN_DIV-COLS-1))) ? ~col_sync_q : samp_q;
  assign proc_en  = scan_en && (p_q >= P_W'(SCAN_DIV-COLS));
  assign col_k    = K_W'(p_q - P_W'(SCAN_DIV-COLS));
  assign key_idx  = I_W'(r_q * COLS + col_k);
  assign evt_code = CODE_W'(key_idx) + CODE_W'(1);

  always_comb begin
    cnt_d     = cnt_q;
    keys_d    = keys_q;
    push      = 1'b0;
    push_data = '0;
    cnt_inc   = cnt_q[key_idx] + 4'd1;
    if (!scan_en) begin
      for (int i = 0; i < NKEYS; i++) cnt_d[i] = '0;
    end else if (proc_en) begin
      if (samp_q[col_k] == keys_q[key_idx]) begin
        cnt_d[key_idx] = '0;
      end else if (cnt_inc == 4'(DEBOUNCE)) begin
        cnt_d[key_idx]  = '0;
        keys_d[key_idx] = ~keys_q[key_idx];
        push            = 1'b1;
        push_data       = {~keys_q[key_idx], evt_code};
      end else begin
        cnt_d[key_idx] = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q     <= '0;
      r_q     <= '0;
      row_n_q <= '1;
      samp_q  <= '0;
      keys_q  <= '0;
      for (int i = 0; i < NKEYS; i++) cnt_q[i] <= '0;
    end else begin
      p_q     <= p_d;
      r_q     <= r_d;
      row_n_q <= row_n_d;
      samp_q  <= samp_d;
      keys_q  <= keys_d;
      cnt_q   <= cnt_d;
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign full   = (fcnt_q == (A_W+1)'(FIFO_DEPTH));
  assign pop    = evt_valid && evt_ready;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_comb begin
    fcnt_d = fcnt_q;
    if (accept && !pop) fcnt_d = fcnt_q + 1'b1;
    else if (!accept && pop) fcnt_d = fcnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (accept) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      fcnt_q <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= push_data;
  end

  assign ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  always_comb begin
    key_enc = '0;
    for (int i = NKEYS-1; i >= 0; i--) begin
      if (keys_q[i]) key_enc = CODE_W'(i+1);
    end
  end

  assign keypad_row_n = row_n_q;
  assign evt_valid    = (fcnt_q != '0);
  assign evt_data     = mem_q[rd_q];
  assign key          = key_enc;
  assign keys_down    = keys_q;
  assign overflow     = ovf_q;

endmodule
